// File: rtl/axis_row_shifter.sv
// axis_row_shifter: takes one wide input beat of IN_WORDS words and emits
// kernel_h_1+1 output beats of CONV_UNITS words. Each one moves one word
// further along the input. Input beats are counted into channel groups, and
// the last output beat of each group carries tlast.
//
// Handshake: an AXI-Stream transfer happens on a rising aclk edge where both
// tvalid and tready are high. tvalid never depends on tready. tdata, tlast and
// tuser stay stable while tvalid is high and tready is low.
//
// Optional feature: define AXIS_ROW_SHIFTER_TUSER_EN to add the m_axis_tuser
// port. It carries {first-output-beat-of-group, shift index}.
module axis_row_shifter #(
    parameter int DATA_WIDTH          = 16,
    parameter int CONV_UNITS          = 8,
    parameter int KERNEL_H_MAX        = 3,
    parameter int CH_IN_COUNTER_WIDTH = 10,
    localparam int IN_WORDS           = CONV_UNITS + KERNEL_H_MAX - 1,
    localparam int KH_W               = (KERNEL_H_MAX > 1) ? $clog2(KERNEL_H_MAX) : 1
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [KH_W-1:0]                   kernel_h_1,
    input  logic [CH_IN_COUNTER_WIDTH-1:0]    im_channels_in_1,
    input  logic [DATA_WIDTH*IN_WORDS-1:0]    s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [DATA_WIDTH*CONV_UNITS-1:0]  m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast
`ifdef AXIS_ROW_SHIFTER_TUSER_EN
    ,
    output logic [KH_W:0]                     m_axis_tuser
`endif
);

    localparam logic [KH_W-1:0] KH_MAX_1 = KH_W'(KERNEL_H_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                           state, state_n;
    logic [KH_W-1:0]                  sh, sh_n;
    logic [KH_W-1:0]                  kh_lat, kh_lat_n;
    logic [CH_IN_COUNTER_WIDTH-1:0]   ch_lat, ch_lat_n;
    logic [CH_IN_COUNTER_WIDTH-1:0]   ch_cnt, ch_cnt_n;
    logic [DATA_WIDTH*IN_WORDS-1:0]   data_q, data_n;
    logic                             s_ready_c;
    logic                             accept;
    logic                             out_hs;
    logic                             last_shift;
    logic                             group_end;

    // State register. Reset drops any held beat and any partial group.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state  <= IDLE;
            sh     <= '0;
            kh_lat <= KH_MAX_1;
            ch_lat <= '0;
            ch_cnt <= '0;
            data_q <= '0;
        end else begin
            state  <= state_n;
            sh     <= sh_n;
            kh_lat <= kh_lat_n;
            ch_lat <= ch_lat_n;
            ch_cnt <= ch_cnt_n;
            data_q <= data_n;
        end
    end

    // Next-state logic: shift on each output handshake. On the last shift,
    // either reload from the input (no bubble) or fall back to IDLE.
    always_comb begin
        state_n    = state;
        sh_n       = sh;
        kh_lat_n   = kh_lat;
        ch_lat_n   = ch_lat;
        ch_cnt_n   = ch_cnt;
        data_n     = data_q;
        s_ready_c  = 1'b0;
        last_shift = (sh == kh_lat);
        out_hs     = (state == SHIFT) && m_axis_tready;

        case (state)
            IDLE: begin
                s_ready_c = 1'b1;
            end
            SHIFT: begin
                s_ready_c = m_axis_tready && last_shift;
                if (out_hs) begin
                    if (!last_shift) begin
                        sh_n   = sh + KH_W'(1);
                        data_n = data_q >> DATA_WIDTH;
                    end else begin
                        ch_cnt_n = (ch_cnt == ch_lat) ? '0 : ch_cnt + CH_IN_COUNTER_WIDTH'(1);
                        state_n  = IDLE;
                        sh_n     = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        accept = s_ready_c && s_axis_tvalid;
        if (accept) begin
            state_n = SHIFT;
            sh_n    = '0;
            data_n  = s_axis_tdata;
            // The count already reflects any group end in this same cycle,
            // so a count of zero here marks the first beat of a new group.
            if (ch_cnt_n == '0) begin
                kh_lat_n = (kernel_h_1 > KH_MAX_1) ? KH_MAX_1 : kernel_h_1;
                ch_lat_n = im_channels_in_1;
            end
        end
    end

    assign group_end     = (ch_cnt == ch_lat);
    assign s_axis_tready = s_ready_c && !areset;
    assign m_axis_tvalid = (state == SHIFT);
    assign m_axis_tdata  = data_q[DATA_WIDTH*CONV_UNITS-1:0];
    assign m_axis_tlast  = (state == SHIFT) && (sh == kh_lat) && group_end;

`ifdef AXIS_ROW_SHIFTER_TUSER_EN
    assign m_axis_tuser = (state == SHIFT) ? {(ch_cnt == '0) && (sh == '0), sh} : '0;
`endif

endmodule
